fwft_word_serializer: RTL and testbench
=======================================

FWFT_WORD_SERIALIZER -- requirements
Module: fwft_word_serializer

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 8: width of one output lane.
REQ-002 SHALL have parameter RATIO, default 8: number of lanes per input word; legal values are powers of two, 2..16.
REQ-003 SHALL derive IN_WIDTH = OUT_WIDTH*RATIO and LANE_BITS = log2(RATIO); neither is overridable.
REQ-004 SHALL have port clk, input, 1: clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port fifo_dout, input, IN_WIDTH: head word of the upstream fall-through FIFO.
REQ-007 SHALL have port fifo_last, input, 1: head word ends a packet.
REQ-008 SHALL have port fifo_lanes, input, LANE_BITS: count of valid lanes in a last word; 0 means all RATIO lanes.
REQ-009 SHALL have port fifo_empty, input, 1: head word is not valid.
REQ-010 SHALL have port fifo_rd_en, output, 1: pops the head word.
REQ-011 SHALL have port out_data, output, OUT_WIDTH: current lane.
REQ-012 SHALL have port out_valid, output, 1: out_data is valid.
REQ-013 SHALL have port out_last, output, 1: final valid lane of a packet.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts the lane.
REQ-015 SHALL have port busy, output, 1: a word is held in the serializer.

Function
REQ-016 SHALL implement two states: EMPTY (no word held) and SHIFT (word held, lane index idx valid).
REQ-017 SHALL assert fifo_rd_en combinationally when !fifo_empty and either the state is EMPTY or the final lane is accepted (out_valid && out_ready && idx==end).
REQ-018 SHALL, on fifo_rd_en, capture fifo_dout, fifo_last and fifo_lanes, set idx=0, and enter SHIFT on the next edge.
REQ-019 SHALL define end = RATIO-1 for non-last words; for last words, end = fifo_lanes-1, or RATIO-1 when fifo_lanes==0.
REQ-020 SHALL drive out_valid=1 in SHIFT only.
REQ-021 SHALL drive out_data = lane idx of the held word, with lane 0 at bits [OUT_WIDTH-1:0].
REQ-022 SHALL drive out_last = held_last && idx==end.
REQ-023 SHALL increment idx on out_valid && out_ready when idx!=end.
REQ-024 SHALL, on acceptance at idx==end, reload (per REQ-018) if fifo_rd_en is asserted, else enter EMPTY.
REQ-025 SHALL have a latency of one cycle from the first cycle fifo_empty=0 while in EMPTY to out_valid=1.
REQ-026 SHALL sustain one lane per cycle across word boundaries while out_ready=1 and the FIFO is non-empty, with no bubbles.
REQ-027 SHALL hold out_data, out_last and out_valid stable while out_valid && !out_ready.
REQ-028 SHALL never assert fifo_rd_en while fifo_empty=1.
REQ-029 SHALL drive busy = (state==SHIFT).

Reset
REQ-030 SHALL, while reset is asserted, force state=EMPTY, idx=0, held data/last/lanes=0, out_valid=0, out_last=0, out_data=0, busy=0 and fifo_rd_en=0.
REQ-031 SHALL, on reset asserted mid-word, discard the remaining lanes; the upstream FIFO is reset in the same cycle.

Configuration
REQ-032 SHALL honour macro FWFT_SERIALIZER_MSB_FIRST_EN: when defined, lane idx maps to bits [(RATIO-idx)*OUT_WIDTH-1 : (RATIO-idx-1)*OUT_WIDTH], so the MSB lane is emitted first and truncated last words keep their upper lanes.
REQ-033 SHALL, when FWFT_SERIALIZER_MSB_FIRST_EN is undefined, behave LSB-first per REQ-021; all other behaviour SHALL be identical in both builds.

Structure
REQ-034 SHALL take the state enum (EMPTY, SHIFT) and the lane-select function from shared package fifo_utils_pkg.
REQ-035 SHALL contain no sub-modules; lane selection is an indexed part-select in the top module.

Verification
REQ-036 Single word: RATIO=8, OUT_WIDTH=8, push 0x0706050403020100 with last=0, out_ready=1 -> out_data 00..07 in 8 consecutive cycles, out_last=0 throughout, one fifo_rd_en pulse.
REQ-037 Back-to-back words: push 2 words -> 16 contiguous valid lanes; the second fifo_rd_en coincides with the cycle lane 7 of word 1 is accepted.
REQ-038 Truncated last word: last=1, lanes=3, data 0x..CCBBAA -> AA, BB, CC; out_last=1 on CC only; next word starts the following cycle.
REQ-039 Backpressure: out_ready toggled 1,0,0,1 -> lane held stable while stalled, no lane lost or duplicated, fifo_rd_en only after the final-lane accept.
REQ-040 Reset mid-word: assert reset after lane 3 -> next cycle out_valid=0, busy=0; after release the first FIFO word is emitted from lane 0.
REQ-041 MSB-first build with FWFT_SERIALIZER_MSB_FIRST_EN defined, same word as REQ-036 -> lanes emitted 07 down to 00.

Source files
------------

// File: rtl/fifo_utils_pkg.sv
// Shared FIFO helper package: serializer state encoding and lane-select mapping.
// Macro FWFT_SERIALIZER_MSB_FIRST_EN: when defined, lane_select maps logical
// lane 0 to the most significant physical lane.
package fifo_utils_pkg;

  // Serializer state: EMPTY holds no word, SHIFT holds a word being emitted.
  typedef enum logic {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Lane indices are sized for the largest supported ratio (16 lanes).
  localparam int unsigned LANE_SEL_BITS = 4;

  // Maps a logical emit index to the physical lane position in the word.
  function automatic logic [LANE_SEL_BITS-1:0] lane_select(
    input logic [LANE_SEL_BITS-1:0] idx,
    input logic [LANE_SEL_BITS:0]   ratio
  );
`ifdef FWFT_SERIALIZER_MSB_FIRST_EN
    return LANE_SEL_BITS'(ratio - (LANE_SEL_BITS+1)'(1) - {1'b0, idx});
`else
    // idx is always below ratio, so the mask is a no-op that bounds the index.
    return idx & LANE_SEL_BITS'(ratio - (LANE_SEL_BITS+1)'(1));
`endif
  endfunction

endpackage

// File: rtl/fwft_word_serializer.sv
// Serializes wide words from a first-word-fall-through FIFO into OUT_WIDTH
// lanes, one lane per cycle, with ready/valid backpressure and packet framing.
// Macro FWFT_SERIALIZER_MSB_FIRST_EN selects MSB-lane-first emission.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   fifo_dout   head word of the upstream FIFO
//   fifo_last   head word ends a packet
//   fifo_lanes  valid lanes in a last word (0 = all RATIO lanes)
//   fifo_empty  head word is not valid
//   fifo_rd_en  pops the head word (combinational)
//   out_data    current lane
//   out_valid   out_data is valid
//   out_last    final valid lane of a packet
//   out_ready   consumer accepts the lane
//   busy        a word is held in the serializer
module fwft_word_serializer
  import fifo_utils_pkg::*;
#(
  parameter  int unsigned OUT_WIDTH = 8,
  parameter  int unsigned RATIO     = 8,
  localparam int unsigned IN_WIDTH  = OUT_WIDTH * RATIO,
  localparam int unsigned LANE_BITS = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  fifo_dout,
  input  logic                 fifo_last,
  input  logic [LANE_BITS-1:0] fifo_lanes,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int unsigned SEL_BITS = $clog2(IN_WIDTH);

  ser_state_e             state_q, state_d;
  logic [LANE_BITS-1:0]   idx_q, idx_d;
  logic [IN_WIDTH-1:0]    held_data_q, held_data_d;
  logic                   held_last_q, held_last_d;
  logic [LANE_BITS-1:0]   held_lanes_q, held_lanes_d;

  logic [LANE_BITS-1:0]     end_idx;
  logic                     shifting;
  logic                     at_end;
  logic                     accept;
  logic                     load;
  logic [LANE_SEL_BITS-1:0] phys_lane;
  logic [SEL_BITS-1:0]      sel_base;

  // Final lane of the held word; a zero lane count on a last word means full.
  always_comb begin
    end_idx = LANE_BITS'(RATIO - 1);
    if (held_last_q && (held_lanes_q != '0)) begin
      end_idx = held_lanes_q - LANE_BITS'(1);
    end
  end

  assign shifting = (state_q == SHIFT);
  assign at_end   = (idx_q == end_idx);
  assign accept   = shifting && out_ready;
  // Pop when idle or when the final lane leaves, so words chain without bubbles.
  assign load     = !reset && !fifo_empty && (!shifting || (accept && at_end));

  // Next-state and holding-register update.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    held_data_d  = held_data_q;
    held_last_d  = held_last_q;
    held_lanes_d = held_lanes_q;
    if (load) begin
      state_d      = SHIFT;
      idx_d        = '0;
      held_data_d  = fifo_dout;
      held_last_d  = fifo_last;
      held_lanes_d = fifo_lanes;
    end else if (accept) begin
      if (at_end) begin
        state_d = EMPTY;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + LANE_BITS'(1);
      end
    end
  end

  // State and holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      idx_q        <= '0;
      held_data_q  <= '0;
      held_last_q  <= 1'b0;
      held_lanes_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      held_data_q  <= held_data_d;
      held_last_q  <= held_last_d;
      held_lanes_q <= held_lanes_d;
    end
  end

  // Lane select: logical index to physical lane, then an indexed part-select.
  assign phys_lane = lane_select(LANE_SEL_BITS'(idx_q), (LANE_SEL_BITS+1)'(RATIO));
  assign sel_base  = SEL_BITS'(phys_lane) * SEL_BITS'(OUT_WIDTH);

  // Outputs are forced quiet for the whole reset cycle, not just after the edge.
  assign fifo_rd_en = load;
  assign out_valid  = shifting && !reset;
  assign busy       = shifting && !reset;
  assign out_last   = shifting && !reset && held_last_q && at_end;
  assign out_data   = reset ? '0 : held_data_q[sel_base +: OUT_WIDTH];

endmodule

// File: tb/tb_fwft_word_serializer.sv
// Directed bench for fwft_word_serializer with a queue-based FWFT FIFO model.
module tb_fwft_word_serializer;

  localparam int unsigned OUT_WIDTH = 8;
  localparam int unsigned RATIO     = 8;
  localparam int unsigned IN_WIDTH  = 64;
  localparam int unsigned LANE_BITS = 3;

  logic                 clk;
  logic                 reset;
  logic [IN_WIDTH-1:0]  fifo_dout;
  logic                 fifo_last;
  logic [LANE_BITS-1:0] fifo_lanes;
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_last;
  logic                 out_ready;
  logic                 busy;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [2:0]  lanes;
  } word_t;

  word_t fifo_q[$];
  int    checks   = 0;
  int    failures = 0;

  fwft_word_serializer #(
    .OUT_WIDTH (OUT_WIDTH),
    .RATIO     (RATIO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_dout  (fifo_dout),
    .fifo_last  (fifo_last),
    .fifo_lanes (fifo_lanes),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Test words put value base+i in lane i, so the emitted order is easy to state.
  function automatic logic [7:0] lane_exp(input logic [7:0] base, input int i);
`ifdef FWFT_SERIALIZER_MSB_FIRST_EN
    return base + 8'(7 - i);
`else
    return base + 8'(i);
`endif
  endfunction

  function automatic logic [63:0] make_word(input logic [7:0] base);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = base + 8'(i);
    return w;
  endfunction

  task automatic present();
    if (fifo_q.size() == 0) begin
      fifo_empty = 1'b1;
      fifo_dout  = '0;
      fifo_last  = 1'b0;
      fifo_lanes = '0;
    end else begin
      fifo_empty = 1'b0;
      fifo_dout  = fifo_q[0].data;
      fifo_last  = fifo_q[0].last;
      fifo_lanes = fifo_q[0].lanes;
    end
    #1;
  endtask

  task automatic push(input logic [63:0] data, input logic last, input logic [2:0] lanes);
    word_t w;
    w.data  = data;
    w.last  = last;
    w.lanes = lanes;
    fifo_q.push_back(w);
    present();
  endtask

  // Crosses one clock edge; the FIFO model pops if rd_en was high before it.
  task automatic advance();
    logic rd;
    rd = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
    present();
  endtask

  task automatic check_lane(input string tag, input logic [7:0] exp_data,
                            input logic exp_last, input logic exp_rd);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'(1));
    check_eq({tag, "_data"},  64'(out_data),  64'(exp_data));
    check_eq({tag, "_last"},  64'(out_last),  64'(exp_last));
    check_eq({tag, "_rd"},    64'(fifo_rd_en), 64'(exp_rd));
  endtask

  initial begin
    logic [7:0] trunc_exp [3];
    logic [1:0] ready_pat [4];
    int         exp_idx;
    int         cyc;
`ifdef FWFT_SERIALIZER_MSB_FIRST_EN
    trunc_exp[0] = 8'h11; trunc_exp[1] = 8'h22; trunc_exp[2] = 8'h33;
`else
    trunc_exp[0] = 8'hAA; trunc_exp[1] = 8'hBB; trunc_exp[2] = 8'hCC;
`endif
    ready_pat[0] = 2'd1; ready_pat[1] = 2'd0; ready_pat[2] = 2'd0; ready_pat[3] = 2'd1;

    reset     = 1'b1;
    out_ready = 1'b1;
    present();
    advance();
    advance();
    check_eq("rst_valid", 64'(out_valid),  64'(0));
    check_eq("rst_busy",  64'(busy),       64'(0));
    check_eq("rst_last",  64'(out_last),   64'(0));
    check_eq("rst_data",  64'(out_data),   64'(0));
    check_eq("rst_rd",    64'(fifo_rd_en), 64'(0));
    push(64'h0706050403020100, 1'b0, 3'd0);
    check_eq("rst_rd_nonempty", 64'(fifo_rd_en), 64'(0));

    // Single word: one pop, then eight lanes in consecutive cycles.
    reset = 1'b0;
    #1;
    check_eq("t1_rd_first", 64'(fifo_rd_en), 64'(1));
    check_eq("t1_pre_valid", 64'(out_valid), 64'(0));
    advance();
    for (int i = 0; i < 8; i++) begin
      check_lane($sformatf("t1_l%0d", i), lane_exp(8'h00, i), 1'b0, 1'b0);
      advance();
    end
    check_eq("t1_end_valid", 64'(out_valid), 64'(0));
    check_eq("t1_end_busy",  64'(busy),      64'(0));

    // Back-to-back words: second pop coincides with lane 7 of the first.
    push(make_word(8'h00), 1'b0, 3'd0);
    push(make_word(8'h10), 1'b0, 3'd0);
    check_eq("t2_rd_first", 64'(fifo_rd_en), 64'(1));
    advance();
    for (int i = 0; i < 16; i++) begin
      check_lane($sformatf("t2_l%0d", i), lane_exp((i < 8) ? 8'h00 : 8'h10, i % 8),
                 1'b0, (i == 7) ? 1'b1 : 1'b0);
      advance();
    end
    check_eq("t2_end_valid", 64'(out_valid), 64'(0));

    // Truncated last word of three lanes, then the next word with no gap.
    push(64'h1122334455CCBBAA, 1'b1, 3'd3);
    push(make_word(8'h20), 1'b0, 3'd0);
    check_eq("t3_rd_first", 64'(fifo_rd_en), 64'(1));
    advance();
    for (int i = 0; i < 3; i++) begin
      check_lane($sformatf("t3_tr%0d", i), trunc_exp[i],
                 (i == 2) ? 1'b1 : 1'b0, (i == 2) ? 1'b1 : 1'b0);
      advance();
    end
    for (int i = 0; i < 8; i++) begin
      check_lane($sformatf("t3_nx%0d", i), lane_exp(8'h20, i), 1'b0, 1'b0);
      advance();
    end
    check_eq("t3_end_valid", 64'(out_valid), 64'(0));

    // Backpressure with ready 1,0,0,1 on a full-length last word.
    push(make_word(8'h30), 1'b1, 3'd0);
    push(make_word(8'h40), 1'b0, 3'd0);
    check_eq("t4_rd_first", 64'(fifo_rd_en), 64'(1));
    advance();
    exp_idx = 0;
    cyc     = 0;
    while ((exp_idx < 8) && (cyc < 64)) begin
      out_ready = ready_pat[cyc % 4][0];
      #1;
      check_lane($sformatf("t4_c%0d", cyc), lane_exp(8'h30, exp_idx),
                 (exp_idx == 7) ? 1'b1 : 1'b0,
                 ((exp_idx == 7) && out_ready) ? 1'b1 : 1'b0);
      advance();
      if (out_ready) exp_idx++;
      cyc++;
    end
    check_eq("t4_bound", 64'(exp_idx), 64'(8));
    check_eq("t4_cycles", 64'(cyc), 64'(16));
    out_ready = 1'b1;
    #1;

    // Next word streams immediately; reset arrives with lane 4 current.
    for (int i = 0; i < 4; i++) begin
      check_lane($sformatf("t5_l%0d", i), lane_exp(8'h40, i), 1'b0, 1'b0);
      advance();
    end
    reset = 1'b1;
    fifo_q.delete();
    present();
    check_eq("t5_rst_valid", 64'(out_valid),  64'(0));
    check_eq("t5_rst_rd",    64'(fifo_rd_en), 64'(0));
    advance();
    check_eq("t5_post_valid", 64'(out_valid), 64'(0));
    check_eq("t5_post_busy",  64'(busy),      64'(0));
    reset = 1'b0;
    push(make_word(8'h50), 1'b0, 3'd0);
    check_eq("t5_rd_first", 64'(fifo_rd_en), 64'(1));
    check_eq("t5_pre_valid", 64'(out_valid), 64'(0));
    advance();
    for (int i = 0; i < 8; i++) begin
      check_lane($sformatf("t5_w%0d", i), lane_exp(8'h50, i), 1'b0, 1'b0);
      advance();
    end
    check_eq("t5_end_busy", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
